// File: rtl/exe_pkg.sv
// Shared definitions for the execute stage: ALU command codes, shift types,
// status-register bit positions and small arithmetic helpers.
package exe_pkg;

  typedef enum logic [3:0] {
    CMD_MOV = 4'b0001,
    CMD_ADD = 4'b0010,
    CMD_ADC = 4'b0011,
    CMD_SUB = 4'b0100,
    CMD_SBC = 4'b0101,
    CMD_AND = 4'b0110,
    CMD_ORR = 4'b0111,
    CMD_EOR = 4'b1000,
    CMD_MVN = 4'b1001
  } exe_cmd_e;

  typedef enum logic [1:0] {
    SH_LSL = 2'b00,
    SH_LSR = 2'b01,
    SH_ASR = 2'b10,
    SH_ROR = 2'b11
  } shift_e;

  localparam int SR_N = 3;
  localparam int SR_Z = 2;
  localparam int SR_C = 1;
  localparam int SR_V = 0;

  function automatic logic [31:0] ror32(input logic [31:0] value, input logic [4:0] amt);
    logic [63:0] doubled;
    doubled = {value, value} >> amt;
    return doubled[31:0];
  endfunction

  // Signed overflow of an addition, judged from the operand and result sign bits.
  function automatic logic add_ovf(input logic a_msb, input logic b_msb, input logic r_msb);
    return (a_msb == b_msb) && (r_msb != a_msb);
  endfunction

endpackage

// File: rtl/exe_stage_checker.sv
// Property checks on the execute stage's reset and freeze behaviour.
module exe_stage_checker (
  input logic        clk,
  input logic        rst,
  input logic        freeze,
  input logic [3:0]  sr,
  input logic        wb_en,
  input logic        mem_r_en,
  input logic        mem_w_en,
  input logic [31:0] alu_res
);

  a_reset_clears: assert property (@(posedge clk)
    !rst |=> (sr == 4'd0 && !wb_en && !mem_r_en && !mem_w_en && alu_res == 32'd0));

  a_freeze_holds: assert property (@(posedge clk)
    (rst && freeze) |=> (sr == $past(sr) && alu_res == $past(alu_res)));

endmodule

// File: rtl/val2_generator.sv
// Second-operand generator: rotated 8-bit immediate, 12-bit memory offset,
// or the Rm register passed through the barrel shifter.
module val2_generator
  import exe_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] Val_Rm_IN,
  input  logic [11:0]      Shift_operand_IN,
  input  logic             imm_IN,
  input  logic             mem_en,
  output logic [WIDTH-1:0] Val2
);

  logic [4:0] shift_amt_s;
  logic [4:0] rot_amt_s;

  assign shift_amt_s = Shift_operand_IN[11:7];
  assign rot_amt_s   = {Shift_operand_IN[11:8], 1'b0};

  // Operand selection; immediate wins over the memory offset form
  always_comb begin
    Val2 = Val_Rm_IN;
    if (imm_IN) begin
      Val2 = ror32({24'd0, Shift_operand_IN[7:0]}, rot_amt_s);
    end else if (mem_en) begin
      Val2 = {20'd0, Shift_operand_IN};
    end else begin
      case (shift_e'(Shift_operand_IN[6:5]))
        SH_LSL:  Val2 = Val_Rm_IN << shift_amt_s;
        SH_LSR:  Val2 = Val_Rm_IN >> shift_amt_s;
        SH_ASR:  Val2 = $unsigned($signed(Val_Rm_IN) >>> shift_amt_s);
        SH_ROR:  Val2 = ror32(Val_Rm_IN, shift_amt_s);
        default: Val2 = Val_Rm_IN;
      endcase
    end
  end

endmodule

// File: rtl/exe_stage.sv
// Execute stage: Val2 generation, ALU with NZCV status register, branch
// target resolution and the EXE/MEM pipeline register.
module exe_stage
  import exe_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             freeze,
  input  logic             WB_EN_IN,
  input  logic             MEM_R_EN_IN,
  input  logic             MEM_W_EN_IN,
  input  logic             B_in,
  input  logic             S_in,
  input  logic [3:0]       EXE_CMD_IN,
  input  logic [WIDTH-1:0] PC_IN,
  input  logic [WIDTH-1:0] Val_Rn_IN,
  input  logic [WIDTH-1:0] Val_Rm_IN,
  input  logic             imm_IN,
  input  logic [11:0]      Shift_operand_IN,
  input  logic [23:0]      Signed_imm_24_IN,
  input  logic [3:0]       Dest_IN,
  output logic [3:0]       SR,
  output logic             Branch_taken,
  output logic [WIDTH-1:0] Branch_Address,
  output logic             WB_EN,
  output logic             MEM_R_EN,
  output logic             MEM_W_EN,
  output logic [WIDTH-1:0] ALU_Res,
  output logic [WIDTH-1:0] Val_Rm,
  output logic [3:0]       Dest
);

  logic             mem_s;
  logic [WIDTH-1:0] val2_s;
  logic [WIDTH-1:0] res_s;
  logic [WIDTH:0]   sum_s;
  logic             c_s;
  logic             v_s;
  logic             flags_ok_s;
  logic             sr_we_s;
  logic [3:0]       sr_next_s;

  assign mem_s = MEM_R_EN_IN | MEM_W_EN_IN;

  val2_generator #(.WIDTH(WIDTH)) u_val2 (
    .Val_Rm_IN        (Val_Rm_IN),
    .Shift_operand_IN (Shift_operand_IN),
    .imm_IN           (imm_IN),
    .mem_en           (mem_s),
    .Val2             (val2_s)
  );

  // ALU; logic and move commands leave C and V at their previous values
  always_comb begin
    sum_s      = '0;
    res_s      = '0;
    c_s        = SR[SR_C];
    v_s        = SR[SR_V];
    flags_ok_s = 1'b1;
    case (EXE_CMD_IN)
      CMD_MOV: res_s = val2_s;
      CMD_MVN: res_s = ~val2_s;
      CMD_AND: res_s = Val_Rn_IN & val2_s;
      CMD_ORR: res_s = Val_Rn_IN | val2_s;
      CMD_EOR: res_s = Val_Rn_IN ^ val2_s;
      CMD_ADD: begin
        sum_s = {1'b0, Val_Rn_IN} + {1'b0, val2_s};
        res_s = sum_s[WIDTH-1:0];
        c_s   = sum_s[WIDTH];
        v_s   = add_ovf(Val_Rn_IN[WIDTH-1], val2_s[WIDTH-1], res_s[WIDTH-1]);
      end
      CMD_ADC: begin
        sum_s = {1'b0, Val_Rn_IN} + {1'b0, val2_s} + {{WIDTH{1'b0}}, SR[SR_C]};
        res_s = sum_s[WIDTH-1:0];
        c_s   = sum_s[WIDTH];
        v_s   = add_ovf(Val_Rn_IN[WIDTH-1], val2_s[WIDTH-1], res_s[WIDTH-1]);
      end
      // Subtraction as Rn + ~Val2 + carry-in, so C comes out as NOT borrow
      CMD_SUB: begin
        sum_s = {1'b0, Val_Rn_IN} + {1'b0, ~val2_s} + {{WIDTH{1'b0}}, 1'b1};
        res_s = sum_s[WIDTH-1:0];
        c_s   = sum_s[WIDTH];
        v_s   = add_ovf(Val_Rn_IN[WIDTH-1], ~val2_s[WIDTH-1], res_s[WIDTH-1]);
      end
      CMD_SBC: begin
        sum_s = {1'b0, Val_Rn_IN} + {1'b0, ~val2_s} + {{WIDTH{1'b0}}, SR[SR_C]};
        res_s = sum_s[WIDTH-1:0];
        c_s   = sum_s[WIDTH];
        v_s   = add_ovf(Val_Rn_IN[WIDTH-1], ~val2_s[WIDTH-1], res_s[WIDTH-1]);
      end
      default: flags_ok_s = 1'b0;
    endcase
    sr_next_s       = SR;
    sr_next_s[SR_N] = res_s[WIDTH-1];
    sr_next_s[SR_Z] = (res_s == '0);
    sr_next_s[SR_C] = c_s;
    sr_next_s[SR_V] = v_s;
  end

  assign sr_we_s = S_in & ~B_in & ~mem_s & flags_ok_s & ~freeze;

  // Status register, written only by flag-setting data-processing ops
  always_ff @(posedge clk) begin
    if (!rst) begin
      SR <= 4'd0;
    end else if (sr_we_s) begin
      SR <= sr_next_s;
    end
  end

  // EXE/MEM pipeline register
  always_ff @(posedge clk) begin
    if (!rst) begin
      WB_EN    <= 1'b0;
      MEM_R_EN <= 1'b0;
      MEM_W_EN <= 1'b0;
      ALU_Res  <= '0;
      Val_Rm   <= '0;
      Dest     <= 4'd0;
    end else if (!freeze) begin
      WB_EN    <= WB_EN_IN;
      MEM_R_EN <= MEM_R_EN_IN;
      MEM_W_EN <= MEM_W_EN_IN;
      ALU_Res  <= res_s;
      Val_Rm   <= Val_Rm_IN;
      Dest     <= Dest_IN;
    end
  end

  assign Branch_taken   = B_in;
  assign Branch_Address = PC_IN + {{(WIDTH-26){Signed_imm_24_IN[23]}}, Signed_imm_24_IN, 2'b00};

  exe_stage_checker u_chk (
    .clk      (clk),
    .rst      (rst),
    .freeze   (freeze),
    .sr       (SR),
    .wb_en    (WB_EN),
    .mem_r_en (MEM_R_EN),
    .mem_w_en (MEM_W_EN),
    .alu_res  (ALU_Res)
  );

endmodule

// File: tb/tb_exe_stage.sv
// Self-checking bench for exe_stage: directed scenarios with literal
// expectations plus randomized traffic against an arithmetic reference model.
module tb_exe_stage;

  logic        clk = 1'b0;
  logic        rst, freeze;
  logic        WB_EN_IN, MEM_R_EN_IN, MEM_W_EN_IN, B_in, S_in;
  logic [3:0]  EXE_CMD_IN;
  logic [31:0] PC_IN, Val_Rn_IN, Val_Rm_IN;
  logic        imm_IN;
  logic [11:0] Shift_operand_IN;
  logic [23:0] Signed_imm_24_IN;
  logic [3:0]  Dest_IN;
  logic [3:0]  SR;
  logic        Branch_taken;
  logic [31:0] Branch_Address;
  logic        WB_EN, MEM_R_EN, MEM_W_EN;
  logic [31:0] ALU_Res, Val_Rm;
  logic [3:0]  Dest;

  int n_checks = 0;
  int n_errors = 0;
  bit chk_en = 1'b0;

  logic [3:0]  exp_sr, exp_dest;
  logic        exp_wb, exp_mr, exp_mw;
  logic [31:0] exp_alu, exp_rm;

  exe_stage #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .freeze(freeze),
    .WB_EN_IN(WB_EN_IN), .MEM_R_EN_IN(MEM_R_EN_IN), .MEM_W_EN_IN(MEM_W_EN_IN),
    .B_in(B_in), .S_in(S_in), .EXE_CMD_IN(EXE_CMD_IN), .PC_IN(PC_IN),
    .Val_Rn_IN(Val_Rn_IN), .Val_Rm_IN(Val_Rm_IN), .imm_IN(imm_IN),
    .Shift_operand_IN(Shift_operand_IN), .Signed_imm_24_IN(Signed_imm_24_IN),
    .Dest_IN(Dest_IN), .SR(SR), .Branch_taken(Branch_taken),
    .Branch_Address(Branch_Address), .WB_EN(WB_EN), .MEM_R_EN(MEM_R_EN),
    .MEM_W_EN(MEM_W_EN), .ALU_Res(ALU_Res), .Val_Rm(Val_Rm), .Dest(Dest)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Second operand, built from bit-at-a-time rotations and shifts
  function automatic logic [31:0] m_val2(input logic imm, input logic mem,
                                         input logic [31:0] rm, input logic [11:0] so);
    logic [31:0] v;
    int n;
    if (imm) begin
      v = {24'd0, so[7:0]};
      n = 2 * int'(so[11:8]);
      for (int i = 0; i < n; i++) v = {v[0], v[31:1]};
    end else if (mem) begin
      v = {20'd0, so};
    end else begin
      v = rm;
      n = int'(so[11:7]);
      for (int i = 0; i < n; i++) begin
        case (so[6:5])
          2'd0:    v = {v[30:0], 1'b0};
          2'd1:    v = {1'b0, v[31:1]};
          2'd2:    v = {v[31], v[31:1]};
          default: v = {v[0], v[31:1]};
        endcase
      end
    end
    return v;
  endfunction

  // ALU on wide integers: carry and overflow judged by range checks
  task automatic m_alu(input logic [3:0] cmd, input logic [31:0] rn, input logic [31:0] v2,
                       input logic cin, input logic vin,
                       output logic [31:0] res, output logic c, output logic v, output logic ok);
    longint a, b, sa, sb, u, s, bor;
    a = longint'(rn); b = longint'(v2);
    sa = longint'($signed(rn)); sb = longint'($signed(v2));
    bor = cin ? 64'sd0 : 64'sd1;
    c = cin; v = vin; ok = 1'b1; res = 32'd0; u = 0; s = 0;
    case (cmd)
      4'd1: res = v2;
      4'd9: res = ~v2;
      4'd6: res = rn & v2;
      4'd7: res = rn | v2;
      4'd8: res = rn ^ v2;
      4'd2: begin u = a + b; s = sa + sb; c = (u > 64'sd4294967295); end
      4'd3: begin u = a + b + (1 - bor); s = sa + sb + (1 - bor); c = (u > 64'sd4294967295); end
      4'd4: begin u = a - b; s = sa - sb; c = (a >= b); end
      4'd5: begin u = a - b - bor; s = sa - sb - bor; c = (a >= b + bor); end
      default: ok = 1'b0;
    endcase
    if (ok && cmd inside {4'd2, 4'd3, 4'd4, 4'd5}) begin
      res = u[31:0];
      v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
    end
  endtask

  // Reference model advanced at each rising edge from the inputs then present
  always @(posedge clk) begin
    logic [31:0] r;
    logic c, v, ok;
    if (!rst) begin
      exp_sr = 4'd0; exp_alu = 32'd0; exp_rm = 32'd0; exp_dest = 4'd0;
      exp_wb = 1'b0; exp_mr = 1'b0; exp_mw = 1'b0;
    end else if (!freeze) begin
      m_alu(EXE_CMD_IN, Val_Rn_IN,
            m_val2(imm_IN, MEM_R_EN_IN | MEM_W_EN_IN, Val_Rm_IN, Shift_operand_IN),
            exp_sr[1], exp_sr[0], r, c, v, ok);
      if (ok && S_in && !B_in && !MEM_R_EN_IN && !MEM_W_EN_IN)
        exp_sr = {r[31], (r == 32'd0), c, v};
      exp_alu = r; exp_rm = Val_Rm_IN; exp_dest = Dest_IN;
      exp_wb = WB_EN_IN; exp_mr = MEM_R_EN_IN; exp_mw = MEM_W_EN_IN;
    end
  end

  // Compare process, half a cycle away from the active edge
  always @(negedge clk) begin
    longint off;
    if (chk_en) begin
      off = longint'(Signed_imm_24_IN) - (Signed_imm_24_IN[23] ? 64'sd16777216 : 64'sd0);
      check("SR", {28'd0, SR}, {28'd0, exp_sr});
      check("WB_EN", {31'd0, WB_EN}, {31'd0, exp_wb});
      check("MEM_R_EN", {31'd0, MEM_R_EN}, {31'd0, exp_mr});
      check("MEM_W_EN", {31'd0, MEM_W_EN}, {31'd0, exp_mw});
      if (exp_wb || exp_mr || exp_mw) check("ALU_Res", ALU_Res, exp_alu);
      check("Val_Rm", Val_Rm, exp_rm);
      check("Dest", {28'd0, Dest}, {28'd0, exp_dest});
      check("Branch_taken", {31'd0, Branch_taken}, {31'd0, B_in});
      check("Branch_Address", Branch_Address, 32'(longint'(PC_IN) + 4 * off));
    end
  end

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in();
    rst = 1'b1; freeze = 1'b0;
    {WB_EN_IN, MEM_R_EN_IN, MEM_W_EN_IN, B_in, S_in, imm_IN} = 6'd0;
    EXE_CMD_IN = 4'd0; PC_IN = 32'd0; Val_Rn_IN = 32'd0; Val_Rm_IN = 32'd0;
    Shift_operand_IN = 12'd0; Signed_imm_24_IN = 24'd0; Dest_IN = 4'd0;
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0:       return 32'h0000_0000;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h7FFF_FFFF;
      3:       return 32'h8000_0000;
      default: return $urandom;
    endcase
  endfunction

  task automatic randomize_in();
    {WB_EN_IN, MEM_R_EN_IN, MEM_W_EN_IN, B_in, S_in} = 5'($urandom);
    if ($urandom_range(0, 1) == 0) {MEM_R_EN_IN, MEM_W_EN_IN, B_in, S_in} = 4'b0001;
    if ($urandom_range(0, 9) == 0) {WB_EN_IN, MEM_R_EN_IN, MEM_W_EN_IN, B_in, S_in} = 5'd0;
    EXE_CMD_IN = 4'($urandom); PC_IN = $urandom;
    Val_Rn_IN = pick(); Val_Rm_IN = pick(); imm_IN = 1'($urandom);
    Shift_operand_IN = 12'($urandom); Signed_imm_24_IN = 24'($urandom);
    Dest_IN = 4'($urandom);
  endtask

  initial begin
    clear_in();
    rst = 1'b0;
    randomize_in();
    cycle();
    randomize_in();
    cycle();
    check("reset SR", {28'd0, SR}, 32'd0);
    check("reset ALU_Res", ALU_Res, 32'd0);
    check("reset ctrl", {29'd0, WB_EN, MEM_R_EN, MEM_W_EN}, 32'd0);
    chk_en = 1'b1;

    clear_in(); WB_EN_IN = 1'b1; EXE_CMD_IN = 4'b0001; imm_IN = 1'b1; Shift_operand_IN = 12'h4FF;
    cycle();
    check("imm rotate", ALU_Res, 32'hFF00_0000);

    clear_in(); WB_EN_IN = 1'b1; EXE_CMD_IN = 4'b0100; Val_Rn_IN = 32'd3; imm_IN = 1'b1;
    Shift_operand_IN = 12'h005; S_in = 1'b1;
    cycle();
    check("sub res", ALU_Res, 32'hFFFF_FFFE);
    check("sub SR", {28'd0, SR}, 32'h8);
    Val_Rn_IN = 32'd5; WB_EN_IN = 1'b0;
    cycle();
    check("cmp SR", {28'd0, SR}, 32'h6);

    clear_in(); WB_EN_IN = 1'b1; EXE_CMD_IN = 4'b0010; Val_Rn_IN = 32'h7FFF_FFFF;
    imm_IN = 1'b1; Shift_operand_IN = 12'h001; S_in = 1'b1;
    cycle();
    check("add ovf res", ALU_Res, 32'h8000_0000);
    check("add ovf SR", {28'd0, SR}, 32'h9);
    Val_Rn_IN = 32'hFFFF_FFFF;
    cycle();
    check("add carry SR", {28'd0, SR}, 32'h6);
    EXE_CMD_IN = 4'b0011; Val_Rn_IN = 32'd1; S_in = 1'b0;
    cycle();
    check("adc res", ALU_Res, 32'd3);

    clear_in(); WB_EN_IN = 1'b1; EXE_CMD_IN = 4'b0010; Val_Rm_IN = 32'h8000_0000;
    Shift_operand_IN = 12'h0C0;
    cycle();
    check("asr res", ALU_Res, 32'hC000_0000);

    clear_in(); WB_EN_IN = 1'b1; MEM_R_EN_IN = 1'b1; EXE_CMD_IN = 4'b0010;
    Val_Rn_IN = 32'h100; Shift_operand_IN = 12'h004; S_in = 1'b1;
    cycle();
    check("ldr addr", ALU_Res, 32'h104);
    check("ldr MEM_R_EN", {31'd0, MEM_R_EN}, 32'd1);
    check("ldr SR kept", {28'd0, SR}, 32'h6);

    clear_in(); B_in = 1'b1; PC_IN = 32'h100; Signed_imm_24_IN = 24'hFFFFFE;
    #1;
    check("branch taken", {31'd0, Branch_taken}, 32'd1);
    check("branch addr", Branch_Address, 32'h0000_00F8);
    cycle();

    clear_in(); WB_EN_IN = 1'b1; EXE_CMD_IN = 4'b0001; imm_IN = 1'b1;
    Shift_operand_IN = 12'h055; S_in = 1'b1;
    cycle();
    check("mov res", ALU_Res, 32'h55);
    check("mov SR", {28'd0, SR}, 32'h2);
    freeze = 1'b1; EXE_CMD_IN = 4'b0100; Shift_operand_IN = 12'h001;
    cycle();
    cycle();
    check("freeze ALU_Res", ALU_Res, 32'h55);
    check("freeze SR", {28'd0, SR}, 32'h2);

    for (int i = 0; i < 3000; i++) begin
      randomize_in();
      rst = ($urandom_range(0, 39) != 0);
      freeze = ($urandom_range(0, 7) == 0);
      cycle();
    end

    clear_in();
    cycle();
    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/exe_stage.md
Name: exe_stage

Overview:
- Execute stage of the ARM-subset 5-stage pipeline: consumer of the ID_Stage_Reg outputs and producer of the ID-side feedback (SR status flags, Branch_taken/Branch_Address to IF).
- Generates Val2, runs the ALU, holds the NZCV status register, resolves branches, and registers results into the EXE/MEM pipeline register.

Parameters:
- WIDTH, 32, datapath width; only 32 is supported.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous, active-low reset; rst==0 at a rising edge resets all state
- freeze  in  1  holds SR and the EXE/MEM register
- WB_EN_IN, MEM_R_EN_IN, MEM_W_EN_IN, B_in, S_in  in  1 each  control bits from ID_Stage_Reg
- EXE_CMD_IN  in  4  ALU command
- PC_IN  in  32  PC+4 of the instruction
- Val_Rn_IN, Val_Rm_IN  in  32 each  operand values
- imm_IN  in  1  immediate-operand flag
- Shift_operand_IN  in  12  shifter field
- Signed_imm_24_IN  in  24  branch offset in words
- Dest_IN  in  4  destination register
- SR  out  4  {N,Z,C,V} status register, fed to ID_Stage
- Branch_taken  out  1  combinational, equal to B_in
- Branch_Address  out  32  combinational branch target
- WB_EN, MEM_R_EN, MEM_W_EN  out  1 each  registered control bits
- ALU_Res  out  32  registered ALU result
- Val_Rm  out  32  registered store data
- Dest  out  4  registered destination register

Behaviour:
- Reset: SR=0 and all registered outputs are 0. Reset takes priority over freeze. A reset asserted mid-instruction drops that instruction; no SR update occurs.
- Latency: ALU_Res, Dest, the control bits and Val_Rm appear 1 cycle after their inputs. SR updates at the same edge. Branch outputs are same-cycle.
- Val2 selection:
  - imm_IN=1: {24'b0, Shift_operand[7:0]} rotated right by 2*Shift_operand[11:8].
  - Else, MEM_R_EN_IN or MEM_W_EN_IN: zero-extended Shift_operand[11:0].
  - Else: Val_Rm_IN shifted by Shift_operand[11:7] using type Shift_operand[6:5]: 00 LSL, 01 LSR, 10 ASR, 11 ROR. A shift amount of 0 passes the value unchanged.
- EXE_CMD and result:
  - 0001 MOV: Val2
  - 1001 MVN: ~Val2
  - 0010 ADD/LDR/STR: Rn+Val2
  - 0011 ADC: Rn+Val2+C
  - 0100 SUB/CMP: Rn-Val2
  - 0101 SBC: Rn-Val2-!C
  - 0110 AND/TST: Rn&Val2
  - 0111 ORR: Rn|Val2
  - 1000 EOR: Rn^Val2
  - Any other code: result 0, no flag change.
- Flags:
  - N=res[31]; Z=(res==0).
  - Arithmetic ops: C=carry-out of the 33-bit add (for SUB/SBC, C=NOT borrow); V=signed overflow.
  - Logic and move ops: C and V keep their previous values.
- SR is written only when S_in=1, B_in=0, MEM_R_EN_IN=0, MEM_W_EN_IN=0, freeze=0 and rst=1.
- Branch_Address = PC_IN + (sign_extend(Signed_imm_24_IN) << 2), modulo 2^32.
- freeze=1: the EXE/MEM register and SR hold. Branch outputs still follow their inputs.
- A bubble (all control bits 0) propagates as zeros in WB_EN/MEM_R_EN/MEM_W_EN. ALU_Res is don't-care for a bubble but is still registered.

Decomposition:
- Package exe_pkg: EXE_CMD constants, shift-type constants, SR bit indices (N=3, Z=2, C=1, V=0).
- Sub-module val2_generator (combinational): inputs Val_Rm_IN, Shift_operand_IN, imm_IN, mem flag; output Val2.
- ALU, SR register and EXE/MEM register stay in exe_stage.

Test Plan:
- Reset: hold rst=0 for 2 edges with random inputs -> SR=0, ALU_Res=0, WB_EN=MEM_R_EN=MEM_W_EN=0.
- Immediate rotate: EXE_CMD=0001, imm=1, Shift_operand=0x4FF -> ALU_Res=0xFF000000 next cycle.
- SUB with S: Val_Rn=3, imm=1, Shift_operand=0x005, S=1 -> ALU_Res=0xFFFFFFFE, SR=1000. Then CMP 5-5 -> SR=0110.
- Overflow and ADC:
  - ADD 0x7FFFFFFF+1, S=1 -> ALU_Res=0x80000000, SR=1001.
  - ADD 0xFFFFFFFF+1, S=1 -> SR=0110.
  - Then ADC 1+1 -> ALU_Res=3.
- Shifted register and memory: Val_Rm=0x80000000, Shift_operand=0x0C0 (ASR #1), ADD with Rn=0 -> 0xC0000000. LDR with Rn=0x100, Shift_operand=0x004 -> ALU_Res=0x104, MEM_R_EN=1, SR unchanged despite S=1.
- Branch and freeze:
  - B=1, PC_IN=0x100, imm24=0xFFFFFE -> Branch_taken=1 and Branch_Address=0xF8 in the same cycle.
  - freeze=1 with S=1 -> SR and ALU_Res hold.
